// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed scan driver for a multi-digit seven-segment
// display (eight segment lines including the decimal point). Each digit gets a
// slot of 2^DIV_W clocks. A frame is DIGITS slots.
//
// The segment patterns and blank mask are copied into shadow registers only at
// the end of a frame, and once on the first clock after reset. Input changes at
// any other time therefore never tear a frame.
//
// Optional feature: define DIM_PWM_EN to enable brightness dimming. Within each
// slot the digit is then driven only while the top four prescaler bits are
// <= brightness, which gives a duty of (brightness+1)/16. Without the macro the
// brightness input is ignored and every digit is driven for the whole slot.
//
// Every output is registered. seg_out, sel_out and frame_tick show the scan
// state of the previous clock.

module seg_scan_mux #(
  parameter int DIGITS      = 6,
  parameter int DIV_W       = 16,
  parameter bit SEL_ACT_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [8*DIGITS-1:0]   seg_in,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic [3:0]            brightness,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     sel_out,
  output logic                  frame_tick
);

  localparam int                IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIV_W-1:0]  P_LAST   = {DIV_W{1'b1}};
  localparam logic [DIV_W-1:0]  P_ONE    = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]  I_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [IDX_W-1:0]  I_ONE    = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [DIGITS-1:0] SEL_IDLE = SEL_ACT_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  // scan state
  logic [DIV_W-1:0]    p_q;
  logic [DIV_W-1:0]    p_d;
  logic [IDX_W-1:0]    idx_q;
  logic [IDX_W-1:0]    idx_d;
  logic                first_q;

  // frame shadows
  logic [8*DIGITS-1:0] shadow_seg_q;
  logic [DIGITS-1:0]   shadow_blank_q;

  // decode
  logic                slot_end;
  logic                frame_end;
  logic                capture;
  logic                pwm_on;
  logic [7:0]          cur_seg;
  logic                cur_blank;
  logic [DIGITS-1:0]   cur_onehot;
  logic                digit_on;

  // next output values
  logic [7:0]          seg_d;
  logic [DIGITS-1:0]   sel_d;

  assign slot_end  = (p_q == P_LAST);
  assign frame_end = slot_end && (idx_q == I_LAST);
  // first_q covers the first clock after reset. After that, capture happens
  // only on the frame boundary.
  assign capture   = first_q || frame_end;

`ifdef DIM_PWM_EN
  assign pwm_on = (p_q[DIV_W-1 -: 4] <= brightness);
`else
  // Dimming is not built in. brightness only feeds this dead-end net so that
  // the port stays present on the interface.
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign pwm_on = 1'b1;
`endif

  // Prescaler and slot index advance. The slot index wraps explicitly at
  // DIGITS-1, so codes above DIGITS-1 are never reached.
  always_comb begin
    p_d   = p_q + P_ONE;
    idx_d = idx_q;
    if (slot_end) begin
      if (idx_q == I_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + I_ONE;
      end
    end
  end

  // Scan state registers. first_q is set during reset and clears after the
  // first clock that follows reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_q     <= '0;
      idx_q   <= '0;
      first_q <= 1'b1;
    end else begin
      p_q     <= p_d;
      idx_q   <= idx_d;
      first_q <= 1'b0;
    end
  end

  // Shadow capture. The capture at the frame boundary lands on the same edge
  // where the index wraps to 0, so the new values first apply in slot 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_seg_q   <= '0;
      shadow_blank_q <= '0;
    end else if (capture) begin
      shadow_seg_q   <= seg_in;
      shadow_blank_q <= blank_mask;
    end
  end

  // Select the current digit's pattern, blank bit and one-hot position with a
  // compare loop. A variable part-select would be out of range for the unused
  // index codes.
  always_comb begin
    cur_seg    = 8'h00;
    cur_blank  = 1'b1;
    cur_onehot = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_seg       = shadow_seg_q[8*k +: 8];
        cur_blank     = shadow_blank_q[k];
        cur_onehot[k] = 1'b1;
      end
    end
  end

  assign digit_on = !cur_blank && pwm_on;

  // Output drive for the current state. An inactive digit releases every
  // select line and every segment line.
  always_comb begin
    seg_d = 8'h00;
    sel_d = SEL_IDLE;
    if (digit_on) begin
      seg_d = cur_seg;
      sel_d = SEL_IDLE ^ cur_onehot;
    end
  end

  // Output registers, one clock behind the scan state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_out    <= 8'h00;
      sel_out    <= SEL_IDLE;
      frame_tick <= 1'b0;
    end else begin
      seg_out    <= seg_d;
      sel_out    <= sel_d;
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
`timescale 1ns/1ps
// Bench for seg_scan_mux. It drives two instances: the default active-low
// six-digit configuration and an active-high four-digit one. A reference model
// steps on every rising edge and pushes the expected outputs to a queue. Each
// test task pops those values on the falling edge and compares them.

module tb_seg_scan_mux;

  localparam int D1   = 6;
  localparam int D2   = 4;
  localparam int DW   = 4;
  localparam int PMAX = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [47:0] seg_in      = '0;
  logic [5:0]  blank_mask  = '0;
  logic [3:0]  brightness  = 4'd15;
  logic [7:0]  seg_out;
  logic [5:0]  sel_out;
  logic        frame_tick;

  logic [31:0] seg_in2     = '0;
  logic [3:0]  blank2      = '0;
  logic [7:0]  seg_out2;
  logic [3:0]  sel_out2;
  logic        frame_tick2;

  always #5 clk = ~clk;

  seg_scan_mux #(.DIGITS(D1), .DIV_W(DW), .SEL_ACT_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .blank_mask(blank_mask),
    .brightness(brightness), .seg_out(seg_out), .sel_out(sel_out),
    .frame_tick(frame_tick)
  );

  seg_scan_mux #(.DIGITS(D2), .DIV_W(DW), .SEL_ACT_LOW(1'b0)) dut2 (
    .clk(clk), .rst(rst), .seg_in(seg_in2), .blank_mask(blank2),
    .brightness(brightness), .seg_out(seg_out2), .sel_out(sel_out2),
    .frame_tick(frame_tick2)
  );

  typedef struct packed {
    logic [7:0] seg;
    logic [7:0] sel;
    logic       ft;
  } exp_t;

  typedef struct packed {
    int          p;
    int          i;
    logic [63:0] sh_seg;
    logic [7:0]  sh_blank;
    bit          first;
  } mstate_t;

  exp_t    sb1[$];
  exp_t    sb2[$];
  mstate_t m1, m2;
  int      n_tests = 0;
  int      n_fail  = 0;

  function automatic mstate_t model_reset();
    mstate_t m;
    m = '0;
    m.first = 1'b1;
    return m;
  endfunction

  function automatic exp_t model_out(input mstate_t m, input int digits,
                                     input bit act_low, input logic [3:0] bright);
    exp_t       e;
    logic [7:0] mask;
    logic [7:0] one;
    bit         pwm;
    mask = 8'((1 << digits) - 1);
    one  = 8'(1 << m.i);
`ifdef DIM_PWM_EN
    pwm = (m.p <= int'(bright));
`else
    pwm = 1'b1;
`endif
    e.ft  = (m.p == PMAX) && (m.i == digits - 1);
    e.seg = 8'h00;
    e.sel = act_low ? mask : 8'h00;
    if (!m.sh_blank[m.i] && pwm) begin
      e.seg = m.sh_seg[8*m.i +: 8];
      e.sel = act_low ? (mask & ~one) : one;
    end
    return e;
  endfunction

  function automatic mstate_t model_next(input mstate_t m, input int digits,
                                         input logic [63:0] sin, input logic [7:0] bin);
    mstate_t n;
    n = m;
    if (m.first || (m.p == PMAX && m.i == digits - 1)) begin
      n.sh_seg   = sin;
      n.sh_blank = bin;
    end
    if (m.p == PMAX) n.i = (m.i == digits - 1) ? 0 : m.i + 1;
    n.p     = (m.p + 1) % 16;
    n.first = 1'b0;
    return n;
  endfunction

  // One clock: the model predicts what the DUTs register at this edge, then
  // the task returns on the falling edge so the caller can sample.
  task automatic step();
    exp_t e1, e2;
    @(posedge clk);
    if (!rst) begin
      m1 = model_reset();
      m2 = model_reset();
      e1 = {8'h00, 8'h3f, 1'b0};
      e2 = {8'h00, 8'h00, 1'b0};
    end else begin
      e1 = model_out(m1, D1, 1'b1, brightness);
      e2 = model_out(m2, D2, 1'b0, brightness);
      m1 = model_next(m1, D1, {16'h0, seg_in}, {2'b0, blank_mask});
      m2 = model_next(m2, D2, {32'h0, seg_in2}, {4'b0, blank2});
    end
    sb1.push_back(e1);
    sb2.push_back(e2);
    @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t e1, e2;
    m1 = model_reset();
    m2 = model_reset();
    seg_in  = 48'h05_04_03_02_01_00;
    seg_in2 = 32'h44_33_22_11;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if ({seg_out, sel_out, frame_tick} !== {8'h00, 6'h3f, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_hold dut1: got seg=%h sel=%b tick=%b, want 00 111111 0", seg_out, sel_out, frame_tick);
    end
    n_tests++;
    if ({seg_out2, sel_out2, frame_tick2} !== {8'h00, 4'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_hold dut2: got seg=%h sel=%b tick=%b, want 00 0000 0", seg_out2, sel_out2, frame_tick2);
    end
    for (int c = 0; c < 6; c++) begin
      if (c == 3) rst = 1'b1;
      step();
      e1 = sb1.pop_front();
      e2 = sb2.pop_front();
      n_tests += 2;
      if ({seg_out, {2'b0, sel_out}, frame_tick} !== e1) begin
        n_fail++;
        $display("FAIL reset_seq dut1 c%0d: got seg=%h sel=%b tick=%b, want seg=%h sel=%b tick=%b", c, seg_out, sel_out, frame_tick, e1.seg, e1.sel, e1.ft);
      end
      if ({seg_out2, {4'b0, sel_out2}, frame_tick2} !== e2) begin
        n_fail++;
        $display("FAIL reset_seq dut2 c%0d: got seg=%h sel=%b tick=%b, want seg=%h sel=%b tick=%b", c, seg_out2, sel_out2, frame_tick2, e2.seg, e2.sel, e2.ft);
      end
    end
  endtask

  task automatic test_scan();
    exp_t e1, e2;
    int   last_tick = -1;
    int   ticks = 0;
    for (int c = 0; c < 200; c++) begin
      step();
      e1 = sb1.pop_front();
      e2 = sb2.pop_front();
      n_tests += 2;
      if ({seg_out, {2'b0, sel_out}, frame_tick} !== e1) begin
        n_fail++;
        $display("FAIL scan dut1 c%0d: got seg=%h sel=%b tick=%b, want seg=%h sel=%b tick=%b", c, seg_out, sel_out, frame_tick, e1.seg, e1.sel, e1.ft);
      end
      if ({seg_out2, {4'b0, sel_out2}, frame_tick2} !== e2) begin
        n_fail++;
        $display("FAIL scan dut2 c%0d: got seg=%h sel=%b tick=%b, want seg=%h sel=%b tick=%b", c, seg_out2, sel_out2, frame_tick2, e2.seg, e2.sel, e2.ft);
      end
      if (frame_tick === 1'b1) begin
        if (last_tick >= 0) begin
          n_tests++;
          if (c - last_tick != 96) begin
            n_fail++;
            $display("FAIL tick_period: got %0d clocks between ticks, want 96", c - last_tick);
          end
        end
        last_tick = c;
        ticks++;
      end
    end
    n_tests++;
    if (ticks < 2) begin
      n_fail++;
      $display("FAIL tick_count: got %0d ticks in 200 clocks, want at least 2", ticks);
    end
  endtask

  task automatic test_tear_free();
    exp_t e1, e2;
    bool_wait: for (int c = 0; c < 200; c++) begin
      if (m1.i == 2 && m1.p == 3) break;
      step();
      void'(sb1.pop_front());
      void'(sb2.pop_front());
    end
    n_tests++;
    if (!(m1.i == 2 && m1.p == 3)) begin
      n_fail++;
      $display("FAIL tear_align: got slot %0d phase %0d, want slot 2 phase 3", m1.i, m1.p);
    end
    seg_in  = 48'hA5_B4_C3_D2_E1_F0;
    seg_in2 = 32'h88_77_66_55;
    for (int c = 0; c < 220; c++) begin
      step();
      e1 = sb1.pop_front();
      e2 = sb2.pop_front();
      n_tests += 2;
      if ({seg_out, {2'b0, sel_out}, frame_tick} !== e1) begin
        n_fail++;
        $display("FAIL tear dut1 c%0d: got seg=%h sel=%b tick=%b, want seg=%h sel=%b tick=%b", c, seg_out, sel_out, frame_tick, e1.seg, e1.sel, e1.ft);
      end
      if ({seg_out2, {4'b0, sel_out2}, frame_tick2} !== e2) begin
        n_fail++;
        $display("FAIL tear dut2 c%0d: got seg=%h sel=%b tick=%b, want seg=%h sel=%b tick=%b", c, seg_out2, sel_out2, frame_tick2, e2.seg, e2.sel, e2.ft);
      end
    end
  endtask

  task automatic test_blank();
    exp_t e1, e2;
    int   ticks = 0;
    for (int c = 0; c < 400; c++) begin
      if (c == 0)   blank_mask = 6'b000100;
      if (c == 200) blank_mask = 6'b111111;
      if (c == 300) blank_mask = 6'b000000;
      step();
      e1 = sb1.pop_front();
      e2 = sb2.pop_front();
      n_tests += 2;
      if ({seg_out, {2'b0, sel_out}, frame_tick} !== e1) begin
        n_fail++;
        $display("FAIL blank dut1 c%0d: got seg=%h sel=%b tick=%b, want seg=%h sel=%b tick=%b", c, seg_out, sel_out, frame_tick, e1.seg, e1.sel, e1.ft);
      end
      if ({seg_out2, {4'b0, sel_out2}, frame_tick2} !== e2) begin
        n_fail++;
        $display("FAIL blank dut2 c%0d: got seg=%h sel=%b tick=%b, want seg=%h sel=%b tick=%b", c, seg_out2, sel_out2, frame_tick2, e2.seg, e2.sel, e2.ft);
      end
      if (c >= 200 && c < 300 && frame_tick === 1'b1) ticks++;
    end
    n_tests++;
    if (ticks != 1) begin
      n_fail++;
      $display("FAIL all_blank_tick: got %0d ticks in 100 clocks, want 1", ticks);
    end
  endtask

  task automatic test_pwm();
    exp_t e1, e2;
    int   active;
    int   want;
    for (int b = 0; b < 2; b++) begin
      brightness = (b == 0) ? 4'd3 : 4'd15;
`ifdef DIM_PWM_EN
      want = (b == 0) ? 24 : 96;
`else
      want = 96;
`endif
      active = 0;
      for (int c = 0; c < 97; c++) begin
        step();
        e1 = sb1.pop_front();
        e2 = sb2.pop_front();
        n_tests += 2;
        if ({seg_out, {2'b0, sel_out}, frame_tick} !== e1) begin
          n_fail++;
          $display("FAIL pwm dut1 b%0d c%0d: got seg=%h sel=%b tick=%b, want seg=%h sel=%b tick=%b", b, c, seg_out, sel_out, frame_tick, e1.seg, e1.sel, e1.ft);
        end
        if ({seg_out2, {4'b0, sel_out2}, frame_tick2} !== e2) begin
          n_fail++;
          $display("FAIL pwm dut2 b%0d c%0d: got seg=%h sel=%b tick=%b, want seg=%h sel=%b tick=%b", b, c, seg_out2, sel_out2, frame_tick2, e2.seg, e2.sel, e2.ft);
        end
        if (c > 0 && sel_out !== 6'h3f) active++;
      end
      n_tests++;
      if (active != want) begin
        n_fail++;
        $display("FAIL pwm_duty b%0d: got %0d active clocks per frame, want %0d", b, active, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e1, e2;
    for (int c = 0; c < 200; c++) begin
      if (m1.i == 4 && m1.p == 5) break;
      step();
      void'(sb1.pop_front());
      void'(sb2.pop_front());
    end
    n_tests++;
    if (!(m1.i == 4 && m1.p == 5)) begin
      n_fail++;
      $display("FAIL rst_align: got slot %0d phase %0d, want slot 4 phase 5", m1.i, m1.p);
    end
    rst = 1'b0;
    #1;
    n_tests += 2;
    if ({seg_out, sel_out, frame_tick} !== {8'h00, 6'h3f, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_async dut1: got seg=%h sel=%b tick=%b, want 00 111111 0", seg_out, sel_out, frame_tick);
    end
    if ({seg_out2, sel_out2, frame_tick2} !== {8'h00, 4'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_async dut2: got seg=%h sel=%b tick=%b, want 00 0000 0", seg_out2, sel_out2, frame_tick2);
    end
    seg_in  = 48'h66_55_44_33_22_11;
    seg_in2 = 32'h0D_0C_0B_0A;
    blank_mask = 6'b100000;
    for (int c = 0; c < 130; c++) begin
      if (c == 3) rst = 1'b1;
      step();
      e1 = sb1.pop_front();
      e2 = sb2.pop_front();
      n_tests += 2;
      if ({seg_out, {2'b0, sel_out}, frame_tick} !== e1) begin
        n_fail++;
        $display("FAIL rst_mid dut1 c%0d: got seg=%h sel=%b tick=%b, want seg=%h sel=%b tick=%b", c, seg_out, sel_out, frame_tick, e1.seg, e1.sel, e1.ft);
      end
      if ({seg_out2, {4'b0, sel_out2}, frame_tick2} !== e2) begin
        n_fail++;
        $display("FAIL rst_mid dut2 c%0d: got seg=%h sel=%b tick=%b, want seg=%h sel=%b tick=%b", c, seg_out2, sel_out2, frame_tick2, e2.seg, e2.sel, e2.ft);
      end
    end
  endtask

  task automatic test_active_high();
    exp_t e1, e2;
    blank_mask = 6'b000000;
    for (int c = 0; c < 160; c++) begin
      if (c == 0)  blank2 = 4'b0000;
      if (c == 80) blank2 = 4'b0100;
      step();
      e1 = sb1.pop_front();
      e2 = sb2.pop_front();
      n_tests += 2;
      if ({seg_out, {2'b0, sel_out}, frame_tick} !== e1) begin
        n_fail++;
        $display("FAIL act_high dut1 c%0d: got seg=%h sel=%b tick=%b, want seg=%h sel=%b tick=%b", c, seg_out, sel_out, frame_tick, e1.seg, e1.sel, e1.ft);
      end
      if ({seg_out2, {4'b0, sel_out2}, frame_tick2} !== e2) begin
        n_fail++;
        $display("FAIL act_high dut2 c%0d: got seg=%h sel=%b tick=%b, want seg=%h sel=%b tick=%b", c, seg_out2, sel_out2, frame_tick2, e2.seg, e2.sel, e2.ft);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before the end of the test sequence");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_scan();
    test_tear_free();
    test_blank();
    test_pwm();
    test_reset_mid();
    test_active_high();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 Parameter DIGITS, default 6, number of multiplexed digits, legal range 2..8.
REQ-002 Parameter DIV_W, default 16, prescaler width; slot period 2^DIV_W clocks, legal range 4..24.
REQ-003 Parameter SEL_ACT_LOW, default 1, 1 = sel_out active-low, 0 = active-high.
REQ-004 clk  input  1  single system clock, rising-edge.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 seg_in  input  8*DIGITS  segment patterns; digit k at [8k+7:8k], bit 7 = decimal point, passed through unmodified.
REQ-007 blank_mask  input  DIGITS  bit k = 1 blanks digit k.
REQ-008 brightness  input  4  PWM duty code; ignored when DIM_PWM_EN is undefined.
REQ-009 seg_out  output  8  registered segment drive for the active digit.
REQ-010 sel_out  output  DIGITS  registered one-hot digit select, polarity per SEL_ACT_LOW.
REQ-011 frame_tick  output  1  registered one-cycle pulse at each frame start.

Function
REQ-012 Prescaler p, DIV_W bits, increments every clock, wraps 2^DIV_W-1 -> 0.
REQ-013 Slot index i advances when p = 2^DIV_W-1, counting 0..DIGITS-1 and wrapping DIGITS-1 -> 0; no other value is ever reached.
REQ-014 Shadow registers capture seg_in and blank_mask on the clock where p = 2^DIV_W-1 and i = DIGITS-1, and on the first clock after reset release; input changes at other times have no effect until the next capture (tear-free frame).
REQ-015 All outputs registered: seg_out/sel_out at cycle t+1 reflect (i, p, shadow) at cycle t; latency exactly one clock.
REQ-016 Digit active when shadow blank bit for i = 0 and pwm_on = 1: sel_out has only bit i asserted, seg_out = shadow pattern for i.
REQ-017 Digit inactive: sel_out all deasserted, seg_out = 8'h00.
REQ-018 frame_tick = 1 for exactly one clock, registered from the cycle where i wraps to 0, i.e. once per DIGITS*2^DIV_W clocks.
REQ-019 Simultaneous capture and slot wrap: the new shadow values apply from slot 0 of the new frame.
REQ-020 All-ones blank_mask: sel_out stays fully deasserted, and frame_tick continues.

Reset
REQ-021 While rst = 0: p = 0, i = 0, shadows = 0, seg_out = 8'h00, sel_out all deasserted (all ones if SEL_ACT_LOW = 1), frame_tick = 0.
REQ-022 Reset asserted mid-frame clears state immediately (asynchronously); after release, the scan restarts at slot 0 with p = 0.

Configuration
REQ-023 Macro DIM_PWM_EN defined: pwm_on = 1 when p[DIV_W-1:DIV_W-4] <= brightness, giving duty (brightness+1)/16 per slot; brightness is sampled every clock.
REQ-024 DIM_PWM_EN undefined: pwm_on is tied to 1, brightness is unconnected internally, and the block behaves as full brightness.

Verification (DIGITS = 6, DIV_W = 4, SEL_ACT_LOW = 1 unless stated)
REQ-025 Reset, release, seg_in = 0x05_04_03_02_01_00, blank_mask = 0 -> seg_out steps 00,01,02,03,04,05 every 16 clocks, sel_out = 6'b111110 then 111101 through 011111, and the pattern repeats.
REQ-026 Change seg_in mid-frame at slot 2 -> seg_out shows old values until slot 0 of the next frame, then shows new values; frame_tick pulses every 96 clocks.
REQ-027 blank_mask = 6'b000100 -> during slot 2, sel_out = 6'b111111 and seg_out = 00; other slots are unaffected.
REQ-028 DIM_PWM_EN defined, brightness = 3 -> per slot, digit active for 4 of 16 clocks (p = 0..3); brightness = 15 -> active for 16 of 16 clocks.
REQ-029 Assert rst during slot 4 for 3 clocks, then release -> outputs are at reset values immediately, and the scan resumes at slot 0 with freshly captured shadows.
REQ-030 SEL_ACT_LOW = 0, DIGITS = 4 -> sel_out = 4'b0001, 0010, 0100, 1000 sequence, with all-zero sel_out when inactive.
